// File: rtl/lru_ctrl_pkg.sv
// lru_ctrl_pkg: shared state encoding, width helper and default sizes for the LRU replacement controller.
package lru_ctrl_pkg;

    typedef enum logic [1:0] {INIT, IDLE, READ, UPDATE} state_t;

    function automatic int clog2w(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_INDEX_BITS = 8;
    localparam int DEPTH          = 1 << DEF_INDEX_BITS;
    localparam int WAY_BITS       = clog2w(DEF_WIDTH);

endpackage

// File: rtl/lru_victim_enc.sv
// lru_victim_enc: lowest-bit priority encoders for the invalid-way mask and the one-hot LRU vector.
module lru_victim_enc
    import lru_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int WB = clog2w(WIDTH)
) (
    input  logic [WIDTH-1:0] invalid,
    input  logic [WIDTH-1:0] vec,
    output logic             inv_any,
    output logic [WB-1:0]    inv_way,
    output logic [WB-1:0]    lru_way
);

    // Scanning downward lets the lowest set bit win; an all-zero input leaves way 0.
    always_comb begin
        inv_way = '0;
        lru_way = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (invalid[i]) inv_way = i[WB-1:0];
            if (vec[i]) lru_way = i[WB-1:0];
        end
    end

    assign inv_any = |invalid;

endmodule

// File: rtl/lru_replace_ctrl.sv
// lru_replace_ctrl: sweeps every LRU set after reset, then serves one lookup per 3 cycles.
// Define LRU_INVALID_FIRST_EN to prefer an invalid way over the LRU way on a miss.
module lru_replace_ctrl
    import lru_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    localparam int WB = clog2w(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic                  req_hit,
    input  logic [WB-1:0]         req_hit_way,
    input  logic [WIDTH-1:0]      way_valid,
    output logic                  resp_valid,
    output logic [WB-1:0]         resp_way,
    output logic                  resp_victim,
    output logic                  init_done,
    output logic                  lru_reset,
    output logic [INDEX_BITS-1:0] lru_index,
    output logic [WB-1:0]         lru_access,
    output logic                  lru_access_valid,
    input  logic [WIDTH-1:0]      lru_vector
);

    state_t state, state_nx;
    logic [INDEX_BITS-1:0] cnt, cap_index;
    logic cap_hit;
    logic [WB-1:0] cap_hit_way, inv_way, lru_way, way;
    logic [WIDTH-1:0] cap_valid, invalid;
    logic inv_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            init_done   <= 1'b0;
            cap_index   <= '0;
            cap_hit     <= 1'b0;
            cap_hit_way <= '0;
            cap_valid   <= '0;
        end else begin
            if (state == INIT) cnt <= cnt + 1'b1;
            if (state == INIT && cnt == '1) init_done <= 1'b1;
            if (state == IDLE && req_valid) begin
                cap_index   <= req_index;
                cap_hit     <= req_hit;
                cap_hit_way <= req_hit_way;
                cap_valid   <= way_valid;
            end
        end
    end

`ifdef LRU_INVALID_FIRST_EN
    assign invalid = ~cap_valid;
`else
    logic unused_valid;
    assign unused_valid = ^cap_valid;
    assign invalid = '0;
`endif

    lru_victim_enc #(.WIDTH(WIDTH)) u_enc (
        .invalid (invalid),
        .vec     (lru_vector),
        .inv_any (inv_any),
        .inv_way (inv_way),
        .lru_way (lru_way)
    );

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    state_nx = (cnt == '1) ? IDLE : INIT;
            IDLE:    state_nx = req_valid ? READ : IDLE;
            READ:    state_nx = UPDATE;
            default: state_nx = IDLE;
        endcase
        way              = cap_hit ? cap_hit_way : inv_any ? inv_way : lru_way;
        req_ready        = (state == IDLE);
        lru_reset        = (state == INIT);
        lru_index        = (state == INIT) ? cnt : cap_index;
        resp_valid       = (state == UPDATE);
        resp_way         = resp_valid ? way : '0;
        resp_victim      = resp_valid & ~cap_hit;
        lru_access       = resp_way;
        lru_access_valid = resp_valid;
    end

endmodule

// File: tb/tb_lru_replace_ctrl.sv
// tb_lru_replace_ctrl: randomized and directed checks of the replacement controller against a rule-level model.
module tb_lru_replace_ctrl;

    localparam int IB = 8;
    localparam int D  = 1 << IB;
`ifdef LRU_INVALID_FIRST_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_hit = 1'b0;
    logic [IB-1:0] req_index = '0;
    logic [1:0] req_hit_way = '0;
    logic [3:0] way_valid = '1, lru_vector = '0;
    logic req_ready, resp_valid, resp_victim, init_done, lru_reset, lru_access_valid;
    logic [1:0] resp_way, lru_access;
    logic [IB-1:0] lru_index;
    int tests = 0, fails = 0;

    lru_replace_ctrl #(.WIDTH(4), .INDEX_BITS(IB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_hit(req_hit), .req_hit_way(req_hit_way),
        .way_valid(way_valid), .resp_valid(resp_valid), .resp_way(resp_way),
        .resp_victim(resp_victim), .init_done(init_done), .lru_reset(lru_reset),
        .lru_index(lru_index), .lru_access(lru_access),
        .lru_access_valid(lru_access_valid), .lru_vector(lru_vector)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Isolate the lowest set bit with x & -x, then take its position.
    function automatic logic [1:0] exp_way(input logic hit, input logic [1:0] hw,
                                           input logic [3:0] wv, input logic [3:0] vec);
        logic [3:0] z, l;
        z = ~wv & (wv + 4'd1);
        l = vec & (~vec + 4'd1);
        if (hit) return hw;
        if (INV_EN && wv != 4'hf) return 2'($clog2(z));
        if (vec == 4'd0) return 2'd0;
        return 2'($clog2(l));
    endfunction

    task automatic check_sweep(input string tag);
        for (int i = 0; i < D; i++) begin
            tests++;
            if ({lru_reset, lru_index, req_ready, resp_valid, init_done} !== {1'b1, IB'(i), 3'b000}) begin
                fails++;
                $display("FAIL %s sweep[%0d]: got reset=%b idx=%0d rdy=%b rv=%b done=%b, want reset=1 idx=%0d rdy=0 rv=0 done=0",
                         tag, i, lru_reset, lru_index, req_ready, resp_valid, init_done, i);
            end
            step();
        end
        tests++;
        if ({init_done, req_ready, lru_reset} !== 3'b110) begin
            fails++;
            $display("FAIL %s sweep_end: got done=%b rdy=%b reset=%b, want 1 1 0", tag, init_done, req_ready, lru_reset);
        end
    endtask

    task automatic do_req(input string tag, input logic [IB-1:0] idx, input logic hit,
                          input logic [1:0] hw, input logic [3:0] wv, input logic [3:0] vec);
        logic [1:0] ew;
        ew = exp_way(hit, hw, wv, vec);
        req_valid = 1'b1; req_index = idx; req_hit = hit; req_hit_way = hw; way_valid = wv;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL %s accept: req_ready=%b, want 1", tag, req_ready);
        end
        step();
        req_valid = 1'b0; req_index = IB'($urandom); req_hit = 1'($urandom);
        req_hit_way = 2'($urandom); way_valid = 4'($urandom); lru_vector = vec;
        tests++;
        if ({resp_valid, req_ready, lru_index} !== {2'b00, idx}) begin
            fails++;
            $display("FAIL %s read: got rv=%b rdy=%b idx=%0d, want 0 0 %0d", tag, resp_valid, req_ready, lru_index, idx);
        end
        step();
        tests++;
        if ({resp_valid, resp_way, resp_victim, lru_access, lru_access_valid, lru_index} !==
            {1'b1, ew, !hit, ew, 1'b1, idx}) begin
            fails++;
            $display("FAIL %s update: got rv=%b way=%0d vic=%b acc=%0d av=%b idx=%0d, want 1 %0d %b %0d 1 %0d",
                     tag, resp_valid, resp_way, resp_victim, lru_access, lru_access_valid, lru_index,
                     ew, !hit, ew, idx);
        end
        step();
        tests++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            fails++; $display("FAIL %s idle: got rv=%b rdy=%b, want 0 1", tag, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        tests++;
        if ({lru_reset, lru_index, req_ready, resp_valid, resp_way, resp_victim, lru_access,
             lru_access_valid, init_done} !== {1'b1, {IB{1'b0}}, 9'd0}) begin
            fails++;
            $display("FAIL reset_values: got reset=%b idx=%0d rdy=%b rv=%b way=%0d vic=%b acc=%0d av=%b done=%b",
                     lru_reset, lru_index, req_ready, resp_valid, resp_way, resp_victim, lru_access,
                     lru_access_valid, init_done);
        end
        step();
        rst_n = 1'b1;
        check_sweep("reset");
    endtask

    task automatic test_directed;
        do_req("hit5", 8'd5, 1'b1, 2'd2, 4'hf, 4'b0100);
        do_req("miss_lru3", 8'd9, 1'b0, 2'd0, 4'hf, 4'b1000);
        do_req("miss_inv", 8'd17, 1'b0, 2'd1, 4'b1011, 4'b0001);
        do_req("miss_zero_vec", 8'd255, 1'b0, 2'd3, 4'hf, 4'b0000);
        do_req("miss_multi", 8'd0, 1'b0, 2'd0, 4'hf, 4'b0110);
        do_req("miss_all_inv", 8'd42, 1'b0, 2'd0, 4'b0000, 4'b1000);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++)
            do_req("rand", IB'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_index = 8'h33; req_hit = 1'b1; req_hit_way = 2'd1; way_valid = 4'hf;
        for (int k = 0; k < 9; k++) begin
            if (k == 2) begin req_index = 8'hc4; req_hit_way = 2'd3; end
            tests++;
            if ({resp_valid, req_ready} !== {k % 3 == 2, k % 3 == 0}) begin
                fails++;
                $display("FAIL b2b[%0d]: got rv=%b rdy=%b, want %b %b", k, resp_valid, req_ready, k % 3 == 2, k % 3 == 0);
            end
            if (k % 3 == 2) begin
                tests++;
                if ({resp_way, lru_index} !== {(k == 2) ? 2'd1 : 2'd3, (k == 2) ? 8'h33 : 8'hc4}) begin
                    fails++;
                    $display("FAIL b2b_resp[%0d]: got way=%0d idx=%0h, want %0d %0h", k, resp_way, lru_index,
                             (k == 2) ? 1 : 3, (k == 2) ? 8'h33 : 8'hc4);
                end
            end
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_sweep;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (100) step();
        tests++;
        if (lru_index !== 8'd100) begin
            fails++; $display("FAIL mid_sweep_pos: lru_index=%0d, want 100", lru_index);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({lru_index, lru_reset, init_done} !== {8'd0, 2'b10}) begin
            fails++; $display("FAIL mid_sweep_reset: idx=%0d reset=%b done=%b, want 0 1 0", lru_index, lru_reset, init_done);
        end
        step();
        rst_n = 1'b1;
        check_sweep("mid_sweep");
    endtask

    task automatic test_reset_in_update;
        req_valid = 1'b1; req_index = 8'd77; req_hit = 1'b0; way_valid = 4'hf; lru_vector = 4'b0010;
        step();
        req_valid = 1'b0;
        step();
        tests++;
        if (resp_valid !== 1'b1) begin
            fails++; $display("FAIL upd_reach: resp_valid=%b, want 1", resp_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({resp_valid, lru_access_valid, lru_index, lru_reset} !== {2'b00, 8'd0, 1'b1}) begin
            fails++;
            $display("FAIL upd_reset: rv=%b av=%b idx=%0d reset=%b, want 0 0 0 1", resp_valid, lru_access_valid, lru_index, lru_reset);
        end
        step();
        rst_n = 1'b1;
        check_sweep("upd_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_sweep();
        test_reset_in_update();
        do_req("post_reset", 8'd5, 1'b1, 2'd2, 4'hf, 4'b0001);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
